// File: rtl/pipo_capture_display_scan.sv
// pipo_capture_display_scan
// Captures a data word on the rising edge of a write-enable level or pulse and
// shows the held word as four hex digits on a multiplexed, active-low
// 7-segment display.
// Optional build macro: BLANK_LEADING_ZEROS_EN. When it is defined, leading
// zero digits (3..1) are blanked and digit 0 is always shown.
module pipo_capture_display_scan #(
    parameter int DATA_W         = 16,
    parameter int REFRESH_CYCLES = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              capture_o,
    output logic [3:0]        anodes_o,
    output logic [6:0]        segments_o
);

    localparam int              CNT_W    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_t;

    logic              r_we_q;
    logic [DATA_W-1:0] r_data;
    logic              r_capture;
    scan_t             r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_anodes;
    logic [6:0]        r_segments;

    logic              w_capture;
    logic              w_wrap;
    logic [3:0]        w_nibble;
    logic              w_blank;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Rising edge of we_i; we_q resets high so a level already present at
    // reset release is not treated as a new event.
    assign w_capture = we_i & ~r_we_q;
    assign w_wrap    = (r_cnt == CNT_LAST);

    // Nibble for the digit currently being scanned.
    always_comb begin
        w_nibble = r_data[3:0];
        case (r_state)
            DIG0: w_nibble = r_data[3:0];
            DIG1: w_nibble = r_data[7:4];
            DIG2: w_nibble = r_data[11:8];
            DIG3: w_nibble = r_data[15:12];
            default: w_nibble = r_data[3:0];
        endcase
    end

`ifdef BLANK_LEADING_ZEROS_EN
    // A digit is blank when it and every more significant digit are zero;
    // digit 0 always shows so an all-zero word still reads "0".
    always_comb begin
        w_blank = 1'b0;
        case (r_state)
            DIG1: w_blank = (r_data[15:4]  == 12'h000);
            DIG2: w_blank = (r_data[15:8]  == 8'h00);
            DIG3: w_blank = (r_data[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    // Edge detector, word capture and one-cycle capture strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we_q    <= 1'b1;
            r_data    <= '0;
            r_capture <= 1'b0;
        end else begin
            r_we_q    <= we_i;
            r_capture <= w_capture;
            if (w_capture)
                r_data <= data_i;
        end
    end

    // Scan FSM: refresh counter, digit state and registered display drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= DIG0;
            r_cnt      <= '0;
            r_anodes   <= 4'b1111;
            r_segments <= 7'h7F;
        end else begin
            case (r_state)
                DIG0:    r_anodes <= 4'b1110;
                DIG1:    r_anodes <= 4'b1101;
                DIG2:    r_anodes <= 4'b1011;
                DIG3:    r_anodes <= 4'b0111;
                default: r_anodes <= 4'b1111;
            endcase
            r_segments <= w_blank ? 7'h7F : hex7(w_nibble);
            if (w_wrap) begin
                r_cnt <= '0;
                case (r_state)
                    DIG0:    r_state <= DIG1;
                    DIG1:    r_state <= DIG2;
                    DIG2:    r_state <= DIG3;
                    default: r_state <= DIG0;
                endcase
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign data_o     = r_data;
    assign capture_o  = r_capture;
    assign anodes_o   = r_anodes;
    assign segments_o = r_segments;

endmodule

// File: tb/tb_pipo_capture_display_scan.sv
// Bench for pipo_capture_display_scan: directed steps plus random stimulus,
// every output compared each cycle against a cycle-count reference model.
module tb_pipo_capture_display_scan;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b1;
    logic [15:0] data_i = 16'h0000;
    logic [15:0] data_o;
    logic        capture_o;
    logic [3:0]  anodes_o;
    logic [6:0]  segments_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_data;
    logic        m_cap;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_weq;
    int          m_edges;

    logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    pipo_capture_display_scan #(.DATA_W(16), .REFRESH_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .data_i(data_i),
        .data_o(data_o), .capture_o(capture_o),
        .anodes_o(anodes_o), .segments_o(segments_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_o"},     32'(data_o),     32'(m_data));
        chk({tag, ".capture_o"},  32'(capture_o),  32'(m_cap));
        chk({tag, ".anodes_o"},   32'(anodes_o),   32'(m_an));
        chk({tag, ".segments_o"}, 32'(segments_o), 32'(m_seg));
        chk({tag, ".onehot"},     32'($countones(~anodes_o) <= 1), 32'd1);
    endtask

    task automatic model_reset();
        m_data = 16'h0; m_cap = 1'b0; m_an = 4'hF; m_seg = 7'h7F;
        m_weq = 1'b1; m_edges = 0;
    endtask

    // One clock edge: the display shows the digit selected by elapsed time
    // (R cycles per digit, four digits round-robin) using the word held
    // before the edge.
    task automatic model_edge();
        int idx;
        logic [15:0] upper;
        idx   = (m_edges / R) % 4;
        upper = m_data >> (4 * idx);
        m_an  = 4'hF & ~(4'b0001 << idx);
        m_seg = HEX[upper[3:0]];
`ifdef BLANK_LEADING_ZEROS_EN
        if (idx != 0 && upper == 16'h0) m_seg = 7'h7F;
`endif
        m_cap = we_i && !m_weq;
        if (m_cap) m_data = data_i;
        m_weq = we_i;
        m_edges++;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges and check that outputs clear at once.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        step({tag, ".held"});
        rst = 1'b0;
    endtask

    task automatic pulse_capture(input logic [15:0] d, input string tag);
        we_i = 1'b1; data_i = d;
        step(tag);
        we_i = 1'b0; data_i = ~d;
        step(tag);
    endtask

    initial begin
        model_reset();
        // Reset state, with we_i already high through release
        step("reset");
        rst = 1'b0;
        step("first_after_reset");
        chk("first.anodes", 32'(anodes_o), 32'h0000000E);
        chk("first.segments", 32'(segments_o), 32'(7'b1000000));
        repeat (3) step("we_high_at_release");
        chk("no_capture_at_release", 32'(data_o), 32'h0);
        we_i = 1'b0;
        step("we_low");

        // Single-cycle pulse capture; later data_i changes must not matter
        pulse_capture(16'hA5C3, "pulse");
        repeat (3) begin data_i = 16'($urandom); step("hold"); end

        // Level enable for 5 cycles with changing data
        we_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_i = 16'h1000 + 16'(i);
            step("level");
        end
        we_i = 1'b0;
        step("level_end");
        chk("level.data", 32'(data_o), 32'h1000);

        // Back-to-back pulses separated by one low cycle
        pulse_capture(16'h1111, "b2b_a");
        pulse_capture(16'h2222, "b2b_b");

        // Full scan of A5C3
        pulse_capture(16'hA5C3, "scan_load");
        repeat (40) step("scan");

        // Capture coinciding with the digit wrap
        while ((m_edges % R) != R - 1) step("align");
        we_i = 1'b1; data_i = 16'hFFFF;
        step("wrap_capture");
        we_i = 1'b0;
        step("wrap_show");
        chk("wrap.segments", 32'(segments_o), 32'(7'b0001110));

        // Leading-zero patterns
        pulse_capture(16'h0012, "lz_0012");
        repeat (20) step("lz_0012_scan");
        pulse_capture(16'h0000, "lz_0000");
        repeat (20) step("lz_0000_scan");

        // Reset mid-scan with a non-zero word held
        pulse_capture(16'h1234, "pre_reset");
        repeat (5) step("pre_reset_scan");
        async_reset("midscan");
        step("post_reset");
        chk("post_reset.anodes", 32'(anodes_o), 32'h0000000E);

        // Randomized traffic with occasional async resets
        for (int i = 0; i < 600; i++) begin
            we_i   = ($urandom_range(0, 3) == 0);
            data_i = 16'($urandom);
            if ($urandom_range(0, 99) == 0) async_reset("rand");
            else step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
